band_eq_mix: RTL and testbench

Downstream stage of the per-band FIR filters in the audio equalizer path. On each sample strobe it snapshots the five band outputs per channel (LP, B1, B2, B3, HP). It applies a per-band pot gain, sums the bands, applies master volume, saturates to 16 bits, and presents one stereo sample to the speaker/PWM driver. A single time-multiplexed multiplier, driven by a small FSM, does all the arithmetic.

---
 rtl/band_eq_mix.sv | 113 +++++++++++
 tb/tb_band_eq_mix.sv | 126 ++++++++++++
 2 files changed

// File: rtl/band_eq_mix.sv
// band_eq_mix: per-band gain, band sum, master volume and 16-bit saturation on one shared multiplier.
module band_eq_mix #(
  parameter int BANDS   = 5,
  parameter int G_SHIFT = 11,
  parameter int V_SHIFT = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] lft_lp,
  input  logic signed [15:0] lft_b1,
  input  logic signed [15:0] lft_b2,
  input  logic signed [15:0] lft_b3,
  input  logic signed [15:0] lft_hp,
  input  logic signed [15:0] rght_lp,
  input  logic signed [15:0] rght_b1,
  input  logic signed [15:0] rght_b2,
  input  logic signed [15:0] rght_b3,
  input  logic signed [15:0] rght_hp,
  input  logic        [11:0] g_lp,
  input  logic        [11:0] g_b1,
  input  logic        [11:0] g_b2,
  input  logic        [11:0] g_b3,
  input  logic        [11:0] g_hp,
  input  logic        [11:0] volume,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               out_vld,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, MAC_L, MAC_R, VOL_L, VOL_R, OUT} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic signed [15:0] in_l[BANDS], in_r[BANDS], sl_q[BANDS], sr_q[BANDS];
  logic [11:0] in_g[BANDS], g_q[BANDS];
  logic [11:0] vol_q;
  logic signed [20:0] acc_l_q, acc_r_q, mul_a;
  logic signed [21:0] tmp_l_q, tmp_r_q;
  logic signed [15:0] lft_q, rght_q;
  logic signed [12:0] mul_b;
  logic signed [33:0] prod, term_g, term_v;
  logic vld_q, start, mac, last;
  assign in_l = '{lft_lp, lft_b1, lft_b2, lft_b3, lft_hp};
  assign in_r = '{rght_lp, rght_b1, rght_b2, rght_b3, rght_hp};
  assign in_g = '{g_lp, g_b1, g_b2, g_b3, g_hp};
  assign start = state_q == IDLE && vld;
  assign mac = state_q == MAC_L || state_q == MAC_R;
  assign last = idx_q == 3'(BANDS - 1);
  // The multiplier is widened to 21 bits on A so the volume pass can reuse it on the accumulators.
  assign mul_a = state_q == MAC_L ? 21'(sl_q[idx_q]) :
                 state_q == MAC_R ? 21'(sr_q[idx_q]) :
                 state_q == VOL_L ? acc_l_q : acc_r_q;
  assign mul_b = mac ? $signed({1'b0, g_q[idx_q]}) : $signed({1'b0, vol_q});
  assign prod = 34'(mul_a) * 34'(mul_b);
  assign term_g = prod >>> G_SHIFT;
  assign term_v = prod >>> V_SHIFT;
  assign lft_out = lft_q;
  assign rght_out = rght_q;
  assign out_vld = vld_q;
  assign busy = state_q != IDLE;
  function automatic logic [15:0] sat(input logic signed [21:0] t);
    return t[21:15] == {7{t[21]}} ? t[15:0] : t[21] ? 16'h8000 : 16'h7fff;
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d = mac ? (last ? 3'd0 : idx_q + 3'd1) : idx_q;
    unique case (state_q)
      IDLE:    state_d = vld ? MAC_L : IDLE;
      MAC_L:   state_d = last ? MAC_R : MAC_L;
      MAC_R:   state_d = last ? VOL_L : MAC_R;
      VOL_L:   state_d = VOL_R;
      VOL_R:   state_d = OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (start) begin
      sl_q <= in_l;
      sr_q <= in_r;
      g_q <= in_g;
      vol_q <= volume;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      tmp_l_q <= '0;
      tmp_r_q <= '0;
      lft_q <= '0;
      rght_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vld_q <= state_q == OUT;
      if (start) begin
        acc_l_q <= '0;
        acc_r_q <= '0;
      end
      if (state_q == MAC_L) acc_l_q <= acc_l_q + $signed(term_g[20:0]);
      if (state_q == MAC_R) acc_r_q <= acc_r_q + $signed(term_g[20:0]);
      if (state_q == VOL_L) tmp_l_q <= term_v[21:0];
      if (state_q == VOL_R) tmp_r_q <= term_v[21:0];
      if (state_q == OUT) begin
        lft_q <= sat(tmp_l_q);
        rght_q <= sat(tmp_r_q);
      end
    end
  end
endmodule

// File: tb/tb_band_eq_mix.sv
// tb_band_eq_mix: directed vectors with hand-computed results for band_eq_mix.
module tb_band_eq_mix;
  logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
  logic signed [15:0] l[5], r[5];
  logic [11:0] g[5];
  logic [11:0] volume;
  logic signed [15:0] lft_out, rght_out;
  logic out_vld, busy;
  int total = 0, bad = 0;
  int lat, pulses, first;
  always #5 clk = ~clk;
  band_eq_mix dut (
    .clk(clk), .rst_n(rst_n), .vld(vld),
    .lft_lp(l[0]), .lft_b1(l[1]), .lft_b2(l[2]), .lft_b3(l[3]), .lft_hp(l[4]),
    .rght_lp(r[0]), .rght_b1(r[1]), .rght_b2(r[2]), .rght_b3(r[3]), .rght_hp(r[4]),
    .g_lp(g[0]), .g_b1(g[1]), .g_b2(g[2]), .g_b3(g[3]), .g_hp(g[4]),
    .volume(volume),
    .lft_out(lft_out), .rght_out(rght_out), .out_vld(out_vld), .busy(busy)
  );
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic setup(input int lv, input int rv, input int gv, input int vv);
    for (int i = 0; i < 5; i++) begin
      l[i] = 16'(lv);
      r[i] = 16'(rv);
      g[i] = 12'(gv);
    end
    volume = 12'(vv);
  endtask
  task automatic run(output int n);
    @(negedge clk) vld = 1'b1;
    @(negedge clk) vld = 1'b0;
    chk("busy_after_vld", busy, 1);
    n = 0;
    while (!out_vld && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 13);
  endtask
  initial begin
    setup(0, 0, 'h800, 'hfff);
    repeat (2) @(negedge clk);
    chk("rst_lft", lft_out, 0);
    chk("rst_rght", rght_out, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    l[0] = 1000;
    r[0] = -1000;
    run(lat);
    chk("unity_l", lft_out, 999);
    chk("unity_r", rght_out, -1000);
    chk("unity_busy", busy, 0);
    @(negedge clk);
    chk("vld_one_cycle", out_vld, 0);
    chk("hold_l", lft_out, 999);
    setup(4000, 0, 'h800, 'hfff);
    run(lat);
    chk("sum_l", lft_out, 19995);
    chk("sum_r", rght_out, 0);
    setup(32767, -32768, 'hfff, 'hfff);
    run(lat);
    chk("sat_pos", lft_out, 32767);
    chk("sat_neg", rght_out, -32768);
    setup(1000, -1000, 'h800, 0);
    run(lat);
    chk("vol0_l", lft_out, 0);
    chk("vol0_r", rght_out, 0);
    setup(0, -100, 'h800, 'hfff);
    l = '{16'sd100, 16'sd200, 16'sd400, 16'sd800, 16'sd1600};
    g[2] = 0;
    run(lat);
    chk("g2_off_l", lft_out, 2699);
    chk("g2_off_r", rght_out, -400);
    // second vld at edge 5 (busy) and edge 13 (OUT cycle) must be dropped; input change at edge 3 ignored
    setup(0, 0, 'h800, 'hfff);
    l[0] = 1000;
    r[0] = -1000;
    @(negedge clk) vld = 1'b1;
    @(negedge clk) vld = 1'b0;
    pulses = 0;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) l[0] = 5000;
      vld = (k == 4 || k == 12);
      if (out_vld) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_latency", first, 13);
    chk("drop_l", lft_out, 999);
    chk("drop_r", rght_out, -1000);
    l[0] = 1000;
    @(negedge clk) vld = 1'b1;
    @(negedge clk) vld = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_l", lft_out, 0);
    chk("midrst_r", rght_out, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_vld) pulses++;
    end
    chk("midrst_no_vld", pulses, 0);
    l[0] = 2000;
    run(lat);
    chk("post_rst_l", lft_out, 1999);
    chk("post_rst_r", rght_out, -1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
